instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Single clock `clk`; reset `reset` is synchronous and active-high; all state updates on rising edge of `clk`.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 pc_value  input  32  current PC word address from the PC block.
REQ-005 pc_inclement  output  1  one-cycle pulse to advance PC by 1.
REQ-006 pc_load  output  1  one-cycle pulse to load PC with pc_load_value.
REQ-007 pc_load_value  output  32  redirect target driven to PC load input.
REQ-008 mem_read  output  1  instruction memory read request, held until mem_ack.
REQ-009 mem_address  output  32  word address of request; equals pc_value while mem_read=1, else 0.
REQ-010 mem_ack  input  1  memory accepts the request and mem_data is valid this cycle.
REQ-011 mem_data  input  32  instruction word returned by memory.
REQ-012 instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-013 instr_ready  input  1  decoder accepts the instruction.
REQ-014 instr  output  32  fetched instruction word.
REQ-015 instr_pc  output  32  word address instr was fetched from.
REQ-016 redirect  input  1  branch/jump request, sampled every cycle.
REQ-017 redirect_target  input  32  new PC value qualified by redirect.

Function
REQ-018 States: IDLE, FETCH, HOLD, REDIRECT; exactly one active per cycle.
REQ-019 IDLE: all request/handshake outputs 0; next state FETCH (unless redirect, REQ-026).
REQ-020 FETCH: mem_read=1, mem_address=pc_value; PC is never incremented or loaded while in FETCH.
REQ-021 FETCH with mem_ack=1: at the edge, instr<=mem_data, instr_pc<=pc_value, next state HOLD; else stay FETCH.
REQ-022 pc_inclement is registered: asserted exactly in the first cycle of HOLD, never otherwise; one pulse per accepted fetch.
REQ-023 HOLD: instr_valid=1; instr and instr_pc stable until handshake completes.
REQ-024 HOLD with instr_ready=1: handshake completes at that edge; next state FETCH; minimum HOLD duration 1 cycle.
REQ-025 Fetch latency: mem_ack at edge k -> instr_valid=1 in cycle k+1; peak throughput 1 instruction per 2 cycles with zero-wait memory.
REQ-026 redirect=1 in any non-reset state: at the edge, pc_load_value<=redirect_target, next state REDIRECT; redirect has priority over mem_ack and instr_ready.
REQ-027 REDIRECT: pc_load=1, instr_valid=0, mem_read=0; next state FETCH; a new redirect in REDIRECT overwrites pc_load_value and stays REDIRECT one more cycle.
REQ-028 redirect and mem_ack in the same FETCH cycle: mem_data discarded, instr/instr_pc unchanged, no pc_inclement pulse.
REQ-029 redirect and instr_ready in the same HOLD cycle: instruction counts as consumed, then REDIRECT.
REQ-030 redirect during first HOLD cycle: pc_inclement completes in that cycle, pc_load follows in the next; pc_load and pc_inclement never asserted in the same cycle.
REQ-031 Dropping mem_read without mem_ack aborts the request; mem_ack arriving when mem_read=0 is ignored.
REQ-032 All arithmetic is 32-bit; PC wrap from 0xFFFFFFFF to 0 is handled by the PC block with no special case here.

Reset
REQ-033 reset=1 at an edge: state<=IDLE; pc_inclement, pc_load, instr_valid, mem_read=0; pc_load_value, instr, instr_pc, mem_address=0.
REQ-034 Reset overrides redirect, mem_ack and instr_ready; mid-fetch reset aborts the request with no pc_inclement; first mem_read no earlier than 2 cycles after reset deasserts.

Verification
REQ-035 Reset release, pc_value=0, mem_ack=1 with mem_data=0x00500093 on the first FETCH cycle -> instr_valid=1 next cycle with instr=0x00500093, instr_pc=0, single pc_inclement pulse.
REQ-036 instr_ready held 0 for 5 cycles in HOLD -> instr_valid, instr, instr_pc stable; pc_inclement high only in the first cycle; no mem_read.
REQ-037 mem_ack delayed 3 cycles -> mem_read and mem_address=pc_value held all 4 cycles; exactly one capture.
REQ-038 redirect=1, redirect_target=47 in the same cycle as mem_ack -> data discarded, pc_load=1 with pc_load_value=47 next cycle, then FETCH with mem_address=47, no pc_inclement.
REQ-039 redirect in the first HOLD cycle -> pc_inclement in that cycle, pc_load next cycle, never both high together.
REQ-040 reset=1 while in FETCH awaiting ack -> mem_read=0 and all outputs at reset values after the edge; ack during reset ignored.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: PC control, instruction memory request and decoder handoff.
// master = fetch unit, slave = surrounding PC block, memory and decoder.
interface instruction_fetch_if;
    logic [31:0] pc_value;
    logic        pc_inclement;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        mem_read;
    logic [31:0] mem_address;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_target;

    modport master (
        input  pc_value, mem_ack, mem_data, instr_ready, redirect, redirect_target,
        output pc_inclement, pc_load, pc_load_value, mem_read, mem_address,
               instr_valid, instr, instr_pc
    );

    modport slave (
        output pc_value, mem_ack, mem_data, instr_ready, redirect, redirect_target,
        input  pc_inclement, pc_load, pc_load_value, mem_read, mem_address,
               instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM: mem_ack at edge k gives instr_valid in cycle k+1 (1 instr / 2 cycles peak).
// Memory wait holds the request; instr_ready low holds the instruction; redirect preempts everything.
module instruction_fetch (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_REDIRECT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_capture;
    logic        r_pc_inc;
    logic [31:0] r_pc_load_value;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Redirect wins over ack and ready; a redirected ack is not captured.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        if (bus.redirect) begin
            w_next_state = S_REDIRECT;
        end else begin
            case (r_state)
                S_IDLE:     w_next_state = S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        w_capture    = 1'b1;
                        w_next_state = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ready) begin
                        w_next_state = S_FETCH;
                    end
                end
                S_REDIRECT: w_next_state = S_FETCH;
                default:    w_next_state = S_IDLE;
            endcase
        end
    end

    // pc_inclement is a registered copy of the capture, so it lands in the first HOLD cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_inc        <= 1'b0;
            r_pc_load_value <= 32'd0;
            r_instr         <= 32'd0;
            r_instr_pc      <= 32'd0;
        end else begin
            r_pc_inc <= w_capture;
            if (bus.redirect) begin
                r_pc_load_value <= bus.redirect_target;
            end
            if (w_capture) begin
                r_instr    <= bus.mem_data;
                r_instr_pc <= bus.pc_value;
            end
        end
    end

    assign bus.mem_read      = (r_state == S_FETCH);
    assign bus.mem_address   = (r_state == S_FETCH) ? bus.pc_value : 32'd0;
    assign bus.instr_valid   = (r_state == S_HOLD);
    assign bus.pc_load       = (r_state == S_REDIRECT);
    assign bus.pc_inclement  = r_pc_inc;
    assign bus.pc_load_value = r_pc_load_value;
    assign bus.instr         = r_instr;
    assign bus.instr_pc      = r_instr_pc;
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table plus a reset-during-fetch sequence.
// A small PC block model drives pc_value from pc_inclement / pc_load.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

    instruction_fetch u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] r_pc = 32'd0;
    always @(posedge clk) begin
        if (reset)                 r_pc <= 32'd0;
        else if (bus.pc_load)      r_pc <= bus.pc_load_value;
        else if (bus.pc_inclement) r_pc <= r_pc + 32'd1;
    end
    assign bus.pc_value = r_pc;

    typedef struct packed {
        logic        rdy;
        logic        ack;
        logic [31:0] dat;
        logic        rd;
        logic [31:0] tgt;
        logic        mrd;
        logic [31:0] maddr;
        logic        vld;
        logic        inc;
        logic        ld;
        logic [31:0] ldv;
        logic [31:0] ins;
        logic [31:0] ipc;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input logic mrd, input logic [31:0] maddr,
                           input logic vld, input logic inc, input logic ld,
                           input logic [31:0] ldv, input logic [31:0] ins, input logic [31:0] ipc);
        chk("mem_read",      row, {31'd0, bus.mem_read},     {31'd0, mrd});
        chk("mem_address",   row, bus.mem_address,           maddr);
        chk("instr_valid",   row, {31'd0, bus.instr_valid},  {31'd0, vld});
        chk("pc_inclement",  row, {31'd0, bus.pc_inclement}, {31'd0, inc});
        chk("pc_load",       row, {31'd0, bus.pc_load},      {31'd0, ld});
        chk("pc_load_value", row, bus.pc_load_value,         ldv);
        chk("instr",         row, bus.instr,                 ins);
        chk("instr_pc",      row, bus.instr_pc,              ipc);
    endtask

    initial begin
        // rdy ack dat rd tgt | mrd maddr vld inc ld ldv ins ipc
        vecs[0]  = '{1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0};
        vecs[1]  = '{1'b0,1'b1,32'h00500093,1'b0,32'h0, 1'b1,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0};
        vecs[2]  = '{1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0,1'b1,1'b1,1'b0,32'h0,32'h00500093,32'h0};
        for (int i = 3; i <= 6; i++)
            vecs[i] = '{1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0,1'b1,1'b0,1'b0,32'h0,32'h00500093,32'h0};
        vecs[7]  = '{1'b1,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0,1'b1,1'b0,1'b0,32'h0,32'h00500093,32'h0};
        for (int i = 8; i <= 10; i++)
            vecs[i] = '{1'b0,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h1,1'b0,1'b0,1'b0,32'h0,32'h00500093,32'h0};
        vecs[11] = '{1'b0,1'b1,32'h11111111,1'b0,32'h0, 1'b1,32'h1,1'b0,1'b0,1'b0,32'h0,32'h00500093,32'h0};
        vecs[12] = '{1'b1,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0,1'b1,1'b1,1'b0,32'h0,32'h11111111,32'h1};
        vecs[13] = '{1'b0,1'b1,32'hDEADBEEF,1'b1,32'd47, 1'b1,32'h2,1'b0,1'b0,1'b0,32'h0,32'h11111111,32'h1};
        vecs[14] = '{1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0,1'b0,1'b0,1'b1,32'd47,32'h11111111,32'h1};
        vecs[15] = '{1'b0,1'b1,32'h22222222,1'b0,32'h0, 1'b1,32'd47,1'b0,1'b0,1'b0,32'd47,32'h11111111,32'h1};
        vecs[16] = '{1'b0,1'b0,32'h0,1'b1,32'h100, 1'b0,32'h0,1'b1,1'b1,1'b0,32'd47,32'h22222222,32'd47};
        vecs[17] = '{1'b0,1'b0,32'h0,1'b1,32'h200, 1'b0,32'h0,1'b0,1'b0,1'b1,32'h100,32'h22222222,32'd47};
        vecs[18] = '{1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0,1'b0,1'b0,1'b1,32'h200,32'h22222222,32'd47};
        vecs[19] = '{1'b0,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h200,1'b0,1'b0,1'b0,32'h200,32'h22222222,32'd47};
        vecs[20] = '{1'b0,1'b1,32'h33333333,1'b0,32'h0, 1'b1,32'h200,1'b0,1'b0,1'b0,32'h200,32'h22222222,32'd47};
        vecs[21] = '{1'b1,1'b0,32'h0,1'b1,32'h10, 1'b0,32'h0,1'b1,1'b1,1'b0,32'h200,32'h33333333,32'h200};
        vecs[22] = '{1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h0,1'b0,1'b0,1'b1,32'h10,32'h33333333,32'h200};
        vecs[23] = '{1'b0,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h10,1'b0,1'b0,1'b0,32'h10,32'h33333333,32'h200};

        reset               = 1'b1;
        bus.mem_ack         = 1'b0;
        bus.mem_data        = 32'h0;
        bus.instr_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all(-1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;

        // Row i is the i-th cycle after reset release; inputs apply to that cycle.
        for (int i = 0; i < NV; i++) begin
            bus.instr_ready     = vecs[i].rdy;
            bus.mem_ack         = vecs[i].ack;
            bus.mem_data        = vecs[i].dat;
            bus.redirect        = vecs[i].rd;
            bus.redirect_target = vecs[i].tgt;
            #1;
            chk_all(i, vecs[i].mrd, vecs[i].maddr, vecs[i].vld, vecs[i].inc, vecs[i].ld,
                    vecs[i].ldv, vecs[i].ins, vecs[i].ipc);
            @(negedge clk);
        end

        // Still in FETCH awaiting ack: reset wins over ack, redirect and ready.
        reset               = 1'b1;
        bus.mem_ack         = 1'b1;
        bus.mem_data        = 32'h44444444;
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'd99;
        bus.instr_ready     = 1'b1;
        @(negedge clk);
        #1;
        chk_all(100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        reset               = 1'b0;
        bus.redirect        = 1'b0;
        bus.instr_ready     = 1'b0;
        #1;
        chk("idle_mem_read", 101, {31'd0, bus.mem_read}, 32'd0);
        @(negedge clk);
        #1;
        chk("fetch_mem_read", 102, {31'd0, bus.mem_read}, 32'd1);
        chk("fetch_addr", 102, bus.mem_address, 32'h0);
        chk("fetch_inc", 102, {31'd0, bus.pc_inclement}, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        #1;
        chk_all(103, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h44444444, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
